// File: rtl/alu_pkg.sv
// Shared encodings, FSM states and default settle latencies for the ALU driver.
// Optional divide-by-zero trap is selected by ALU_DRV_DIVZERO_TRAP_EN.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_MUL = 3'b011,
    ALU_DIV = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_ILL = 3'b111
  } alu_sel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam int DEF_ADD_LAT = 1;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alu_drv_lat.sv
// Maps an ALU select code to its settle-cycle count; 0 marks an illegal op.
// Part of alu_driver (see ALU_DRV_DIVZERO_TRAP_EN in the top).
module alu_drv_lat
  import alu_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = 5
) (
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] lat
);

  logic is_fast;

  always_comb begin
    is_fast = (sel == ALU_ADD) || (sel == ALU_SUB) ||
              (sel == ALU_AND) || (sel == ALU_OR);
    lat = '0;
    unique case (1'b1)
      is_fast:          lat = CNT_W'(ADD_LAT);
      (sel == ALU_MUL): lat = CNT_W'(MUL_LAT);
      (sel == ALU_DIV): lat = CNT_W'(DIV_LAT);
      default:          lat = '0;
    endcase
  end

endmodule

// File: rtl/alu_driver.sv
// Sequential initiator for the 64-bit combinational ALU with req/rsp handshakes.
// Define ALU_DRV_DIVZERO_TRAP_EN to answer divide-by-zero with an error response.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int TAG_W   = 5,
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sel,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_o_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_z_f,
  output logic             rsp_o_f,
  output logic             rsp_err
);

  localparam int MAX_LAT = max3(ADD_LAT, MUL_LAT, DIV_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat;
  logic             acc;
  logic             legal;
  logic             trap;
  logic             start;
  logic             last;

  alu_drv_lat #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_lat (
    .sel(req_sel),
    .lat(lat)
  );

  always_comb begin
    acc   = req_valid && (state == S_IDLE);
    legal = (lat != '0);
`ifdef ALU_DRV_DIVZERO_TRAP_EN
    trap  = (req_sel == ALU_DIV) && (req_b == '0);
`else
    trap  = 1'b0;
`endif
    start = acc && legal && !trap;
    last  = (state == S_EXEC) && (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = start ? S_EXEC : S_RESP;
      end
      S_EXEC: if (last) state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Illegal and trapped ops never reach the ALU; they answer with a fixed error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= ALU_NOP;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_z_f    <= 1'b0;
      rsp_o_f    <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (acc) begin
      rsp_tag <= req_tag;
      if (start) begin
        alu_a   <= req_a;
        alu_b   <= req_b;
        alu_sel <= req_sel;
        cnt     <= lat;
      end else begin
        rsp_result <= '0;
        rsp_z_f    <= 1'b1;
        rsp_o_f    <= 1'b0;
        rsp_err    <= 1'b1;
      end
    end else if (state == S_EXEC) begin
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        rsp_result <= alu_result;
        rsp_z_f    <= ~|alu_result;
        rsp_o_f    <= alu_o_f;
        rsp_err    <= 1'b0;
        alu_sel    <= ALU_NOP;
      end
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
// Directed table-driven bench for alu_driver with a behavioural ALU model.
// Divide-by-zero expectations follow ALU_DRV_DIVZERO_TRAP_EN.
module tb_alu_driver;
  import alu_pkg::*;

  localparam int W  = 64;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_sel;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [TW-1:0] req_tag;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_sel;
  logic [W-1:0]  alu_result;
  logic          alu_o_f;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          rsp_z_f;
  logic          rsp_o_f;
  logic          rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_driver dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .alu_o_f   (alu_o_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_tag   (rsp_tag),
    .rsp_z_f   (rsp_z_f),
    .rsp_o_f   (rsp_o_f),
    .rsp_err   (rsp_err)
  );

  // ALU model; idle select yields a poison value so a stray capture shows up.
  always_comb begin
    alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    alu_o_f    = 1'b1;
    case (alu_sel)
      ALU_ADD: begin
        alu_result = alu_a + alu_b;
        alu_o_f = (alu_a[63] == alu_b[63]) &&
                  (alu_result[63] != alu_a[63]);
      end
      ALU_SUB: begin
        alu_result = alu_a - alu_b;
        alu_o_f = (alu_a[63] != alu_b[63]) &&
                  (alu_result[63] != alu_a[63]);
      end
      ALU_MUL: begin
        alu_result = alu_a * alu_b;
        alu_o_f = 1'b0;
      end
      ALU_DIV: begin
        alu_result = (alu_b == '0) ? '1 : alu_a / alu_b;
        alu_o_f = 1'b0;
      end
      ALU_AND: begin
        alu_result = alu_a & alu_b;
        alu_o_f = 1'b0;
      end
      ALU_OR: begin
        alu_result = alu_a | alu_b;
        alu_o_f = 1'b0;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0]    sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic          z;
    logic          o;
    logic          err;
    int            lat;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int stall);
    int n;
    rsp_ready = (stall == 0);
    req_sel   = t.sel;
    req_a     = t.a;
    req_b     = t.b;
    req_tag   = t.tag;
    req_valid = 1'b1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = ~t.a;
    req_b     = ~t.b;
    req_tag   = ~t.tag;
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    n = 0;
    while (!rsp_valid && n < 40) begin
      chk("alu_sel_exec", 64'(alu_sel), 64'(t.sel));
      chk("alu_a_exec", alu_a, t.a);
      chk("alu_b_exec", alu_b, t.b);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(t.lat));
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_result", rsp_result, t.res);
    chk("rsp_z_f", 64'(rsp_z_f), 64'(t.z));
    chk("rsp_o_f", 64'(rsp_o_f), 64'(t.o));
    chk("rsp_err", 64'(rsp_err), 64'(t.err));
    chk("rsp_tag", 64'(rsp_tag), 64'(t.tag));
    if (t.lat == 0) chk("alu_sel_nop", 64'(alu_sel), 64'(ALU_NOP));
    if (stall > 0) begin
      req_sel   = ALU_ADD;
      req_a     = 64'd1;
      req_b     = 64'd1;
      req_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk("stall_valid", 64'(rsp_valid), 64'd1);
        chk("stall_result", rsp_result, t.res);
        chk("stall_tag", 64'(rsp_tag), 64'(t.tag));
        chk("stall_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_done", 64'(rsp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_z_f", 64'(rsp_z_f), 64'd0);
    chk("rst_o_f", 64'(rsp_o_f), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_sel", 64'(alu_sel), 64'd0);
  endtask

  initial begin
    v[0]  = '{ALU_ADD, 64'd5, 64'd7, 5'd3, 64'd12,
               1'b0, 1'b0, 1'b0, 1};
    v[1]  = '{ALU_SUB, 64'd9, 64'd9, 5'd1, 64'd0,
               1'b1, 1'b0, 1'b0, 1};
    v[2]  = '{ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd2,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1};
    v[3]  = '{ALU_MUL, 64'd3, 64'd4, 5'd4, 64'd12,
               1'b0, 1'b0, 1'b0, 4};
    v[4]  = '{ALU_DIV, 64'd100, 64'd7, 5'd5, 64'd14,
               1'b0, 1'b0, 1'b0, 16};
    v[5]  = '{ALU_AND, 64'hF0, 64'h3C, 5'd6, 64'h30,
               1'b0, 1'b0, 1'b0, 1};
    v[6]  = '{ALU_OR, 64'h0, 64'h0, 5'd7, 64'h0,
               1'b1, 1'b0, 1'b0, 1};
    v[7]  = '{ALU_ILL, 64'd11, 64'd22, 5'd9, 64'd0,
               1'b1, 1'b0, 1'b1, 0};
    v[8]  = '{ALU_NOP, 64'd1, 64'd2, 5'd10, 64'd0,
               1'b1, 1'b0, 1'b1, 0};
    v[9]  = '{ALU_SUB, 64'd3, 64'd5, 5'd31,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1};
`ifdef ALU_DRV_DIVZERO_TRAP_EN
    v[10] = '{ALU_DIV, 64'd5, 64'd0, 5'd12, 64'd0,
              1'b1, 1'b0, 1'b1, 0};
`else
    v[10] = '{ALU_DIV, 64'd5, 64'd0, 5'd12, '1,
              1'b0, 1'b0, 1'b0, 16};
`endif

    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk_reset_vals();

    for (int i = 0; i < 11; i++) run(v[i], (i == 4) ? 10 : 0);

    // Reset while a multiply is in flight must drop it silently.
    req_sel   = ALU_MUL;
    req_a     = 64'd3;
    req_b     = 64'd4;
    req_tag   = 5'd4;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_req_ready2", 64'(req_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    run(v[3], 0);
    run(v[0], 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
